// File: rtl/rp_pin_pkg.sv
// Shared definitions for the pin driver: FSM encoding and parameter defaults.
package rp_pin_pkg;

    // Default number of high-Z cycles inserted before driving a released pin.
    localparam int TURN_CYCLES_DEF = 2;
    // Default width of the per-command hold count.
    localparam int HOLD_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/rp_pin_driver_if.sv
// Command channel into the pin driver.
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high; cmd_dir/cmd_val/cmd_hold are sampled only on that
// edge, and the offering side may change or withdraw them at any other time.
interface rp_pin_driver_if
    import rp_pin_pkg::*;
#(
    parameter int HOLD_W = HOLD_W_DEF
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic              cmd_val;
    logic [HOLD_W-1:0] cmd_hold;

    modport master (
        output cmd_valid, cmd_dir, cmd_val, cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_val, cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/rp_dly_cnt.sv
// Loadable down-counter with a zero flag; times both the turnaround and the hold phase.
module rp_dly_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/rp_pin_driver.sv
// Registered I/T driver for an external 3-state pad buffer. Inserts high-Z
// turnaround cycles before taking a released pin back to drive, then holds off
// new commands for the per-command hold count.
module rp_pin_driver
    import rp_pin_pkg::*;
#(
    parameter int TURN_CYCLES = TURN_CYCLES_DEF,
    parameter int HOLD_W      = HOLD_W_DEF
) (
    input  logic                  clk,
    input  logic                  aresetn,
    rp_pin_driver_if.slave        cmd,
    input  logic                  cnt_preset_en,   // loads cmd_count (bring-up/test)
    input  logic [31:0]           cnt_preset_val,
    output logic                  val_out,
    output logic                  direction,
    output logic                  busy,
    output logic [31:0]           cmd_count,
    output state_t                state_dbg
);
    localparam int CNT_W = (HOLD_W > 4) ? HOLD_W : 4;

    state_t            state_q,    state_d;
    logic              dir_q,      dir_d;
    logic              val_q,      val_d;
    logic              ready_q,    ready_d;
    logic [31:0]       count_q,    count_d;
    logic              lat_val_q,  lat_val_d;
    logic [HOLD_W-1:0] lat_hold_q, lat_hold_d;

    logic              accept;
    logic              out_done;
    logic [HOLD_W-1:0] hold_sel;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              cnt_zero;

    assign accept = cmd.cmd_valid && ready_q;

    rp_dly_cnt #(.W(CNT_W)) u_dly_cnt (
        .clk      (clk),
        .aresetn  (aresetn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Next-state, pin outputs, counter control and ready; the counter is loaded
    // with N-1 so its zero flag marks the last cycle of an N-cycle phase.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        val_d        = val_q;
        count_d      = count_q;
        lat_val_d    = lat_val_q;
        lat_hold_d   = lat_hold_q;
        out_done     = 1'b0;
        hold_sel     = lat_hold_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    count_d    = count_q + 32'd1;
                    lat_val_d  = cmd.cmd_val;
                    lat_hold_d = cmd.cmd_hold;
                    if (cmd.cmd_dir || !dir_q || (TURN_CYCLES == 0)) begin
                        // Release, drive-to-drive, or no turnaround configured.
                        dir_d = cmd.cmd_dir;
                        if (!cmd.cmd_dir) begin
                            val_d = cmd.cmd_val;
                        end
                        out_done = 1'b1;
                        hold_sel = cmd.cmd_hold;
                    end else begin
                        state_d      = ST_TURN;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(TURN_CYCLES - 1);
                    end
                end
            end
            ST_TURN: begin
                if (cnt_zero) begin
                    dir_d    = 1'b0;
                    val_d    = lat_val_q;
                    out_done = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs just took their commanded values: hold off, or straight back to IDLE.
        if (out_done) begin
            if (hold_sel == '0) begin
                state_d = ST_IDLE;
            end else begin
                state_d      = ST_HOLD;
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(hold_sel) - CNT_W'(1);
            end
        end

        if (cnt_preset_en) begin
            count_d = cnt_preset_val;
        end

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any pending drive and releases the pin.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b1;
            val_q      <= 1'b0;
            ready_q    <= 1'b0;
            count_q    <= 32'd0;
            lat_val_q  <= 1'b0;
            lat_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            val_q      <= val_d;
            ready_q    <= ready_d;
            count_q    <= count_d;
            lat_val_q  <= lat_val_d;
            lat_hold_q <= lat_hold_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign val_out       = val_q;
    assign direction     = dir_q;
    assign busy          = (state_q != ST_IDLE);
    assign cmd_count     = count_q;
    assign state_dbg     = state_q;
endmodule
